alu_div: RTL and testbench

Iterative radix-2 integer divider for the RV M-extension DIV/DIVU/REM/REMU and their W forms. It sits in the execute stage beside `alu` and consumes the same forwarded `op1`/`op2` operand registers that feed `alu`. It returns one quotient or remainder per accepted request over a valid/ready handshake. The core stalls on `in_ready`/`out_valid` while a division is in flight.

---
 rtl/alu_div.sv | 169 ++++++++++++++++
 tb/tb_alu_div.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_div.sv
`default_nettype none
// ============================================================================
//  Module   : alu_div
//  Purpose  : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU (+W).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_div #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            w,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int SH    = XLEN - 32;
    localparam logic [XLEN-1:0] c_min_x = {XLEN{1'b1}} << (XLEN - 1);
    localparam logic [XLEN-1:0] c_min_w = {XLEN{1'b1}} << 31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;
    logic             r_w;
    logic [XLEN-1:0]  r_result;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] t;
        t = x << SH;
        return $unsigned($signed(t) >>> SH);
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] t;
        t = x << SH;
        return t >> SH;
    endfunction

    // Operand preparation for the request currently offered
    logic            w_w;
    logic            w_signed;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_dvd_load;

    assign w_w        = (XLEN == 32) ? 1'b0 : w;
    assign w_signed   = funct3[2] & ~funct3[0];
    assign w_a        = w_w ? (w_signed ? sext32(op1) : zext32(op1)) : op1;
    assign w_b        = w_w ? (w_signed ? sext32(op2) : zext32(op2)) : op2;
    assign w_sign_a   = w_signed & w_a[XLEN-1];
    assign w_sign_b   = w_signed & w_b[XLEN-1];
    assign w_mag_a    = w_sign_a ? -w_a : w_a;
    assign w_mag_b    = w_sign_b ? -w_b : w_b;
    assign w_div_zero = (w_b == '0);
    assign w_ovf      = w_signed & (w_a == (w_w ? c_min_w : c_min_x)) & (&w_b);
    // W dividends start at the top so 32 shifts consume exactly their bits
    assign w_dvd_load = w_w ? (w_mag_a << SH) : w_mag_a;

    logic [XLEN:0]   w_trial;
    logic            w_fits;
    assign w_trial = {r_rem, r_quo[XLEN-1]} - {1'b0, r_div};
    assign w_fits  = ~w_trial[XLEN];

    logic [XLEN-1:0] w_q;
    logic [XLEN-1:0] w_r;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_fin;
    assign w_q   = r_neg_q ? -r_quo : r_quo;
    assign w_r   = r_neg_r ? -r_rem : r_rem;
    assign w_sel = r_is_rem ? w_r : w_q;
    assign w_fin = r_w ? sext32(w_sel) : w_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_w      <= 1'b0;
            r_result <= '0;
        end else if (kill) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_w      <= w_w;
                        r_is_rem <= funct3[1];
                        r_div    <= w_mag_b;
                        // Special cases skip RUN; FIX still applies W extension
                        if (w_div_zero) begin
                            r_quo   <= '1;
                            r_rem   <= w_a;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= S_FIX;
                        end else if (w_ovf) begin
                            r_quo   <= w_a;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= S_FIX;
                        end else begin
                            r_quo   <= w_dvd_load;
                            r_rem   <= '0;
                            r_neg_q <= w_sign_a ^ w_sign_b;
                            r_neg_r <= w_sign_a;
                            r_cnt   <= w_w ? CNT_W'(32) : CNT_W'(XLEN);
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_fits ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
                    r_quo <= {r_quo[XLEN-2:0], w_fits};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fin;
                    r_state  <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_div
//  Purpose  : Directed self-checking bench for alu_div (XLEN=64).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_div;

    localparam int XLEN = 64;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic            w;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    int checks = 0;
    int errors = 0;

    alu_div #(.XLEN(XLEN)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct3   (funct3),
        .w        (w),
        .op1      (op1),
        .op2      (op2),
        .kill     (kill),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request and return once it is accepted
    task automatic issue(input logic [2:0] f, input logic wf, input logic [63:0] a, input logic [63:0] b);
        @(negedge clock);
        funct3   = f;
        w        = wf;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic handoff(input string tag);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_out_valid_after"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic wf,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        issue(f, wf, a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp);
        handoff(tag);
    endtask

    // Abort an op at RUN step 10 with reset or kill, then confirm recovery
    task automatic abort_test(input string tag, input logic use_reset);
        bit seen;
        int lat;
        issue(3'b100, 1'b0, 64'd1000, 64'd3);
        repeat (9) @(posedge clock);
        @(negedge clock);
        if (use_reset) reset = 1'b1;
        else           kill  = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        kill  = 1'b0;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_no_pulse"}, {63'd0, seen}, 64'd0);
        issue(3'b101, 1'b0, 64'd100, 64'd7);
        wait_valid(lat);
        check({tag, "_fresh_lat"}, 64'(lat), 64'd65);
        check({tag, "_fresh_res"}, result, 64'd14);
        handoff({tag, "_fresh"});
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        funct3    = 3'b100;
        w         = 1'b0;
        op1       = '0;
        op2       = '0;
        kill      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("div_20_m3",  3'b100, 1'b0, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        run_op("rem_20_m3",  3'b110, 1'b0, 64'd20, -64'sd3, 64'h0000_0000_0000_0002, 65);
        run_op("divu_by0",   3'b101, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu_by0",   3'b111, 1'b0, 64'h1234, 64'd0, 64'h0000_0000_0000_1234, 1);
        run_op("div_ovf",    3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf",    3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run_op("divw",       3'b100, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 33);
        run_op("divuw",      3'b101, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33);
        run_op("div_m7_2",   3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_m7_2",   3'b110, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("remuw",      3'b111, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd2, 33);

        // Hold the result in DONE with out_ready low
        issue(3'b101, 1'b0, 64'd100, 64'd7);
        wait_valid(lat);
        check("hold_lat", 64'(lat), 64'd65);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("hold_result", result, 64'd14);
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        handoff("hold");

        abort_test("reset_mid_run", 1'b1);
        abort_test("kill_mid_run", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
